// File: rtl/boot_loader_ctrl_pkg.sv
// rtl/boot_loader_ctrl_pkg.sv - boot loader states, header codes, dst indices
// ST_CHK is present only when BOOT_CHECKSUM_EN is defined.
package boot_loader_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_HDR,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_PAYLOAD,
`ifdef BOOT_CHECKSUM_EN
    ST_CHK,
`endif
    ST_DONE,
    ST_ERR
  } boot_state_t;

  localparam logic [7:0] BOOT_HDR_INSTR = 8'hA5;
  localparam logic [7:0] BOOT_HDR_DATA  = 8'h5A;
  localparam logic [7:0] BOOT_HDR_END   = 8'hFF;

  localparam int DST_IMEM = 2;
  localparam int DST_DMEM = 1;
  localparam int DST_RSVD = 0;
endpackage

// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared datapath widths for the boot subsystem
package common_pkg;
  localparam int BITS  = 32;
  localparam int ADDRW = 7;
endpackage

// File: rtl/boot_word_assembler.sv
// rtl/boot_word_assembler.sv - packs little-endian bytes into BITS-wide words
// o_word/o_word_ready are valid in the cycle the last byte of a word is presented.
module boot_word_assembler
  import common_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clear,
  input  logic            i_byte_valid,
  input  logic [7:0]      i_byte,
  output logic [BITS-1:0] o_word,
  output logic            o_word_ready
);
  localparam int NBYTES = BITS / 8;
  localparam int CW     = $clog2(NBYTES);

  logic [CW-1:0]   r_cnt;
  logic [BITS-9:0] r_shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_shreg <= '0;
    end else if (i_clear) begin
      r_cnt   <= '0;
    end else if (i_byte_valid) begin
      r_cnt   <= r_cnt + 1'b1;
      r_shreg <= {i_byte, r_shreg[BITS-9:8]};
    end
  end

  // Earlier bytes sit in the shift register, so the final byte lands on top.
  assign o_word       = {i_byte, r_shreg};
  assign o_word_ready = i_byte_valid && !i_clear && (r_cnt == CW'(NBYTES - 1));
endmodule

// File: rtl/boot_loader_ctrl.sv
// rtl/boot_loader_ctrl.sv - serial boot loader: sections of words into imem/dmem
// Optional BOOT_CHECKSUM_EN adds a per-section XOR check byte.
module boot_loader_ctrl
  import common_pkg::*;
  import boot_loader_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  output logic            bootloading,
  output logic [BITS-1:0] wdata_data,
  output logic [ADDRW:0]  wdata_addr,
  output logic [2:0]      dst,
  output logic            boot_err
);
`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_t ST_SECT_END = ST_CHK;
`else
  localparam boot_state_t ST_SECT_END = ST_HDR;
`endif

  boot_state_t     r_state, w_state;
  logic [15:0]     r_count, w_count;
  logic [ADDRW:0]  r_addr, w_addr;
  logic            r_sel_imem, w_sel_imem;
  logic            r_bootloading, w_bootloading;
  logic [BITS-1:0] r_wdata_data, w_wdata_data;
  logic [ADDRW:0]  r_wdata_addr, w_wdata_addr;
  logic [2:0]      r_dst, w_dst;
  logic            r_boot_err, w_boot_err;
  logic [BITS-1:0] w_word;
  logic            w_word_ready;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]      r_xor, w_xor;
`endif

  boot_word_assembler u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (r_state != ST_PAYLOAD),
    .i_byte_valid (rx_valid && (r_state == ST_PAYLOAD)),
    .i_byte       (rx_data),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_HDR;
      r_count       <= '0;
      r_addr        <= '0;
      r_sel_imem    <= 1'b0;
      r_bootloading <= 1'b1;
      r_wdata_data  <= '0;
      r_wdata_addr  <= '0;
      r_dst         <= '0;
      r_boot_err    <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      r_xor         <= '0;
`endif
    end else begin
      r_state       <= w_state;
      r_count       <= w_count;
      r_addr        <= w_addr;
      r_sel_imem    <= w_sel_imem;
      r_bootloading <= w_bootloading;
      r_wdata_data  <= w_wdata_data;
      r_wdata_addr  <= w_wdata_addr;
      r_dst         <= w_dst;
      r_boot_err    <= w_boot_err;
`ifdef BOOT_CHECKSUM_EN
      r_xor         <= w_xor;
`endif
    end
  end

  always_comb begin
    w_state      = r_state;
    w_count      = r_count;
    w_addr       = r_addr;
    w_sel_imem   = r_sel_imem;
    w_wdata_data = r_wdata_data;
    w_wdata_addr = r_wdata_addr;
    w_dst        = '0;
`ifdef BOOT_CHECKSUM_EN
    w_xor        = r_xor;
`endif
    case (r_state)
      ST_HDR: begin
`ifdef BOOT_CHECKSUM_EN
        w_xor = '0;
`endif
        if (rx_valid) begin
          w_addr = '0;
          case (rx_data)
            BOOT_HDR_INSTR: begin w_sel_imem = 1'b1; w_state = ST_CNT_LO; end
            BOOT_HDR_DATA:  begin w_sel_imem = 1'b0; w_state = ST_CNT_LO; end
            BOOT_HDR_END:   w_state = ST_DONE;
            default:        w_state = ST_ERR;
          endcase
        end
      end
      ST_CNT_LO: if (rx_valid) begin
        w_count = {r_count[15:8], rx_data};
        w_state = ST_CNT_HI;
      end
      ST_CNT_HI: if (rx_valid) begin
        w_count = {rx_data, r_count[7:0]};
        w_state = ({rx_data, r_count[7:0]} == 16'd0) ? ST_SECT_END : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
`ifdef BOOT_CHECKSUM_EN
        if (rx_valid) w_xor = r_xor ^ rx_data;
`endif
        if (w_word_ready) begin
          w_dst[DST_IMEM] = r_sel_imem;
          w_dst[DST_DMEM] = !r_sel_imem;
          w_wdata_data    = w_word;
          w_wdata_addr    = r_addr;
          w_addr          = r_addr + 1'b1;
          w_count         = r_count - 16'd1;
          if (r_count == 16'd1) w_state = ST_SECT_END;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      ST_CHK: if (rx_valid) w_state = (rx_data == r_xor) ? ST_HDR : ST_ERR;
`endif
      default: ;
    endcase
    w_bootloading = (w_state != ST_DONE);
    w_boot_err    = (w_state == ST_ERR);
  end

  assign bootloading = r_bootloading;
  assign wdata_data  = r_wdata_data;
  assign wdata_addr  = r_wdata_addr;
  assign dst         = r_dst;
  assign boot_err    = r_boot_err;
endmodule

// File: tb/tb_boot_loader_ctrl.sv
// tb/tb_boot_loader_ctrl.sv - self-checking bench for boot_loader_ctrl (BOOT_CHECKSUM_EN aware)
module tb_boot_loader_ctrl;
  import common_pkg::*;
  localparam int AW = ADDRW + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rx_valid = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            bootloading;
  logic [BITS-1:0] wdata_data;
  logic [ADDRW:0]  wdata_addr;
  logic [2:0]      dst;
  logic            boot_err;

  boot_loader_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .bootloading(bootloading), .wdata_data(wdata_data), .wdata_addr(wdata_addr),
    .dst(dst), .boot_err(boot_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]      dst;
    logic [ADDRW:0]  addr;
    logic [BITS-1:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         log_q[$];
  logic [31:0] g_words[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          m_boot = 1'b1;
  bit          m_err = 1'b0;
  int          m_mode = 0;   // 0 loading, 1 done, 2 error
  int          base;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xor_bytes(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

  always @(negedge clk) begin : compare
    wr_t e;
    wr_t a;
    chk("bootloading", {63'd0, bootloading}, {63'd0, m_boot});
    chk("boot_err", {63'd0, boot_err}, {63'd0, m_err});
    if (dst != 3'b000) begin
      a.dst = dst; a.addr = wdata_addr; a.data = wdata_data;
      log_q.push_back(a);
      if (exp_q.size() == 0) begin
        chk("unexpected_write_dst", 64'(dst), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("write_dst", 64'(dst), 64'(e.dst));
        chk("write_addr", 64'(wdata_addr), 64'(e.addr));
        chk("write_data", 64'(wdata_data), 64'(e.data));
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("missing_write_dst", 64'(dst), 64'(e.dst));
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Sends header, count, payload words (and check byte when enabled); queues expected writes.
  task automatic send_section(input logic [7:0] hdr, input bit gaps, input bit bad_chk);
    bit          live = (m_mode == 0);
    logic [15:0] n16 = 16'(g_words.size());
    logic [7:0]  x = 8'h00;
    logic [31:0] w;
    wr_t         e;
    send_byte(hdr);
    if (gaps) idle($urandom_range(0, 2));
    send_byte(n16[7:0]);
    send_byte(n16[15:8]);
    for (int i = 0; i < g_words.size(); i++) begin
      w = g_words[i];
      for (int b = 0; b < 4; b++) begin
        if (gaps) idle($urandom_range(0, 2));
        send_byte(w[8*b +: 8]);
      end
      x ^= xor_bytes(w);
      if (live) begin
        e.dst  = (hdr == 8'hA5) ? 3'b100 : 3'b010;
        e.addr = AW'(i % (1 << AW));
        e.data = w;
        exp_q.push_back(e);
      end
    end
`ifdef BOOT_CHECKSUM_EN
    send_byte(bad_chk ? (x ^ 8'h01) : x);
    if (live && bad_chk) begin
      m_mode = 2;
      m_err  = 1'b1;
    end
`else
    if (bad_chk || x == 8'h00) idle(0);
`endif
  endtask

  task automatic send_end();
    send_byte(8'hFF);
    if (m_mode == 0) begin
      m_mode = 1;
      m_boot = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    m_boot = 1'b1;
    m_err  = 1'b0;
    m_mode = 0;
    #1;
    chk("rst_bootloading", 64'(bootloading), 64'd1);
    chk("rst_boot_err", 64'(boot_err), 64'd0);
    chk("rst_dst", 64'(dst), 64'd0);
    chk("rst_wdata_data", 64'(wdata_data), 64'd0);
    chk("rst_wdata_addr", 64'(wdata_addr), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Instruction section, two words, then end marker.
    g_words = '{32'h44332211, 32'h88776655};
    send_section(8'hA5, 1'b0, 1'b0);
    chk("pre_end_bootloading", 64'(bootloading), 64'd1);
    send_end();
    chk("end_bootloading", 64'(bootloading), 64'd0);
    idle(2);
    chk("instr_write_count", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      chk("instr_w0_dst", 64'(log_q[0].dst), 64'h4);
      chk("instr_w0_addr", 64'(log_q[0].addr), 64'd0);
      chk("instr_w0_data", 64'(log_q[0].data), 64'h44332211);
      chk("instr_w1_addr", 64'(log_q[1].addr), 64'd1);
      chk("instr_w1_data", 64'(log_q[1].data), 64'h88776655);
    end
    do_reset();

    // Zero-count data section.
    base = log_q.size();
    g_words.delete();
    send_section(8'h5A, 1'b0, 1'b0);
    idle(3);
    send_end();
    idle(2);
    chk("zero_count_writes", 64'(log_q.size()), 64'(base));
    chk("zero_count_done", 64'(bootloading), 64'd0);

    // Reset mid-payload, then a fresh one-word section.
    do_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    do_reset();
    base = log_q.size();
    g_words = '{32'hDEADBEEF};
    send_section(8'hA5, 1'b0, 1'b0);
    idle(2);
    chk("post_rst_writes", 64'(log_q.size()), 64'(base + 1));
    if (log_q.size() == base + 1) begin
      chk("post_rst_addr", 64'(log_q[base].addr), 64'd0);
      chk("post_rst_data", 64'(log_q[base].data), 64'hDEADBEEF);
    end

    // Data section with idle gaps, then a long back-to-back section that wraps the address.
    g_words = '{32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF};
    send_section(8'h5A, 1'b1, 1'b0);
    g_words.delete();
    for (int i = 0; i < (1 << AW) + 2; i++) g_words.push_back((i * 32'h01000193) ^ 32'h5A5A0000);
    send_section(8'h5A, 1'b0, 1'b0);
    idle(2);
    chk("wrap_last_addr", 64'(log_q[log_q.size()-1].addr), 64'd1);
    send_end();
    idle(2);
    do_reset();

    // Unknown header locks into error; later sections write nothing.
    send_byte(8'h3C);
    if (m_mode == 0) begin m_mode = 2; m_err = 1'b1; end
    idle(1);
    chk("bad_hdr_err", 64'(boot_err), 64'd1);
    chk("bad_hdr_boot", 64'(bootloading), 64'd1);
    base = log_q.size();
    g_words = '{32'h11111111};
    send_section(8'hA5, 1'b0, 1'b0);
    idle(3);
    chk("err_no_writes", 64'(log_q.size()), 64'(base));
    do_reset();

`ifdef BOOT_CHECKSUM_EN
    chk("xor_pin", 64'(xor_bytes(32'h08040201)), 64'h0F);
    base = log_q.size();
    g_words = '{32'h08040201};
    send_section(8'hA5, 1'b0, 1'b0);
    idle(2);
    chk("chk_ok_writes", 64'(log_q.size()), 64'(base + 1));
    chk("chk_ok_err", 64'(boot_err), 64'd0);
    send_section(8'hA5, 1'b0, 1'b1);
    idle(2);
    chk("chk_bad_err", 64'(boot_err), 64'd1);
    chk("chk_bad_writes_kept", 64'(log_q.size()), 64'(base + 2));
    do_reset();
`endif

    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/boot_loader_ctrl.md
BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

Interface
REQ-001 SHALL provide: clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL provide: rst_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL provide: rx_valid  input  1  one-cycle strobe; a received byte is on rx_data.
REQ-004 SHALL provide: rx_data  input  8  received byte, sampled only when rx_valid=1.
REQ-005 SHALL provide: bootloading  output  1  high while the CPU is held in boot.
REQ-006 SHALL provide: wdata_data  output  BITS  assembled word to be written.
REQ-007 SHALL provide: wdata_addr  output  ADDRW+1  word address of the write.
REQ-008 SHALL provide: dst  output  3  write strobes: [2] instruction memory, [1] data memory, [0] reserved, always 0.
REQ-009 SHALL provide: boot_err  output  1  sticky protocol error flag.

Function
REQ-010 SHALL implement the FSM states HDR, CNT_LO, CNT_HI, PAYLOAD, CHK, DONE and ERR; CHK exists only under REQ-027.
REQ-011 HDR state, on an accepted byte:
- 0xA5: select instruction memory, go to CNT_LO.
- 0x5A: select data memory, go to CNT_LO.
- 0xFF: go to DONE.
- any other value: go to ERR.
REQ-012 CNT_LO and CNT_HI SHALL capture a 16-bit word count, little-endian, then go to PAYLOAD.
REQ-013 A word count of 0 SHALL skip PAYLOAD and go to CHK if enabled, else to HDR.
REQ-014 PAYLOAD SHALL assemble each 4 bytes little-endian into one BITS word: byte 0 goes to [7:0].
REQ-015 The cycle after the 4th byte of a word is accepted, the block SHALL drive the selected dst bit high for exactly one cycle, together with the word on wdata_data and the current address on wdata_addr.
REQ-016 The word address SHALL restart at 0 for each section and increment by 1 after each write.
- The address wraps modulo 2^(ADDRW+1).
- Wrap-around SHALL NOT raise an error.
REQ-017 After the last word of a section, the FSM SHALL go to CHK if enabled, else to HDR.
REQ-018 rx_valid arriving in the same cycle as a write strobe SHALL be accepted normally; no byte is ever dropped and no back-pressure exists.
REQ-019 bootloading SHALL be 1 in every state except DONE.
- It falls in the cycle after the 0xFF byte is accepted.
REQ-020 DONE and ERR SHALL ignore rx_valid; only rst_n leaves them.
REQ-021 ERR SHALL hold boot_err=1 and bootloading=1, and SHALL issue no further writes.
REQ-022 All outputs SHALL be registered; dst SHALL be 0 in every cycle that is not a write cycle.

Reset
REQ-023 Asserting rst_n low SHALL immediately (asynchronously) force:
- state HDR, bootloading=1, dst=0, wdata_data=0, wdata_addr=0, boot_err=0;
- byte counter, word counter and checksum cleared.
REQ-024 Reset in the middle of a section SHALL discard any partial word; no write strobe is issued for it.

Configuration
REQ-025 Macro BOOT_CHECKSUM_EN SHALL select the checksum feature.
REQ-026 Without BOOT_CHECKSUM_EN:
- no CHK state and no checksum logic;
- boot_err is set only by an unknown header.
REQ-027 With BOOT_CHECKSUM_EN:
- a running XOR covers all payload bytes of a section and is cleared in HDR.
- After the payload, CHK accepts one byte: if it equals the XOR, go to HDR; if not, go to ERR.
- Writes already issued for the section are not undone.

Structure
REQ-028 The shared parameter package SHALL hold:
- the FSM state enum boot_state_t;
- header constants BOOT_HDR_INSTR=8'hA5, BOOT_HDR_DATA=8'h5A, BOOT_HDR_END=8'hFF;
- the dst bit indices.
BITS and ADDRW SHALL come from the existing common parameter package.
REQ-029 A single sub-module, boot_word_assembler, SHALL hold the byte counter, the shift register and the word-ready pulse; all else stays in the top FSM.

Verification
REQ-030 Instruction section: A5 02 00 11 22 33 44 55 66 77 88, then FF ->
- dst=3'b100 with addr 0 / 32'h44332211, then addr 1 / 32'h88776655;
- bootloading falls one cycle after FF.
REQ-031 Data section with count 0 (5A 00 00), then FF -> no dst pulse; FSM returns to HDR, then DONE.
REQ-032 Unknown header 0x3C -> boot_err=1 and bootloading stays 1; a following A5 01 00 ... produces no writes.
REQ-033 Assert rst_n after 2 payload bytes, then release and send a full 1-word section -> exactly one write, at addr 0, with the new data.
REQ-034 BOOT_CHECKSUM_EN: A5 01 00 01 02 04 08, then 0F -> one write, return to HDR; the same stream ending in 0E -> ERR, boot_err=1.
REQ-035 rx_valid pulses back-to-back every cycle across word boundaries -> every word is written correctly with no lost bytes.
